// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a single registered output entry.
// Channel choice is either an explicit select or round-robin arbitration.
module stream_mux_rr #(
  parameter int unsigned N     = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  input  logic               mode,
  input  logic [SELW-1:0]    sel,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_chan,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int unsigned PW = SELW + 1;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [SELW-1:0]  out_chan_q, out_chan_d;
  logic [SELW-1:0]  rr_ptr_q, rr_ptr_d;

  logic             load_en;
  logic             sel_valid;
  logic [2*N-1:0]   rr_rot;
  logic [SELW-1:0]  rr_off;
  logic [PW-1:0]    rr_sum;
  logic [SELW-1:0]  rr_grant;
  logic [SELW-1:0]  grant;
  logic             grant_valid;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;

  // Grant selection for both modes; a rotated valid vector finds the first requester from rr_ptr.
  always_comb begin
    load_en   = !out_valid_q || out_ready;
    sel_valid = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (sel == SELW'(i)) sel_valid = in_valid[i];
    end
    rr_rot = {in_valid, in_valid} >> rr_ptr_q;
    rr_off = '0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      if (rr_rot[k]) rr_off = SELW'(k);
    end
    rr_sum = PW'(rr_ptr_q) + PW'(rr_off);
    if (rr_sum >= PW'(N)) rr_sum = rr_sum - PW'(N);
    rr_grant    = rr_sum[SELW-1:0];
    grant       = mode ? rr_grant : sel;
    grant_valid = mode ? (|in_valid) : sel_valid;
    grant_data  = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (grant == SELW'(i)) grant_data = in_data[i*WIDTH +: WIDTH];
    end
    for (int i = 0; i < int'(N); i++) begin
      in_ready[i] = rst_n && load_en && grant_valid && (grant == SELW'(i));
    end
    xfer = load_en && grant_valid;
  end

  // Next-state for the output entry and the round-robin pointer.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    rr_ptr_d    = rr_ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = grant_data;
      out_chan_d  = grant;
      if (mode) rr_ptr_d = (grant == SELW'(N - 1)) ? '0 : grant + SELW'(1);
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: a behavioural model predicts grants and beats,
// a separate monitor checks every beat the DUT presents.
module tb_stream_mux_rr;
  localparam int unsigned N    = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned SELW = 2;

  typedef struct packed {
    logic [W-1:0]    d;
    logic [SELW-1:0] c;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic             mode;
  logic [SELW-1:0]  sel;
  logic [W-1:0]     out_data;
  logic [SELW-1:0]  out_chan;
  logic             out_valid;
  logic             out_ready;

  logic [W-1:0] chan_data [N];
  beat_t        sb_q [$];
  int           total = 0;
  int           bad = 0;
  bit           model_occ;
  int           model_rr;

  stream_mux_rr #(.N(N), .WIDTH(W), .SELW(SELW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mode(mode), .sel(sel), .out_data(out_data),
    .out_chan(out_chan), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < int'(N); i++) in_data[i*W +: W] = chan_data[i];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference arbitration: first valid channel scanning from the pointer, or the selected channel.
  task automatic model_grant(output int g, output bit gv);
    g = 0;
    gv = 1'b0;
    if (mode) begin
      for (int k = 0; k < int'(N); k++) begin
        int c;
        c = (model_rr + k) % int'(N);
        if (!gv && in_valid[c]) begin
          g = c;
          gv = 1'b1;
        end
      end
    end else begin
      g = int'(sel);
      gv = (g < int'(N)) && in_valid[g];
    end
  endtask

  task automatic drive(input logic [N-1:0] v, input logic m, input logic [SELW-1:0] s,
                       input logic ordy);
    in_valid = v;
    mode = m;
    sel = s;
    out_ready = ordy;
  endtask

  // One clock: check handshake at the falling edge, update the model, advance past the rising edge.
  task automatic cycle();
    int g;
    bit gv;
    bit load;
    logic [N-1:0] exp_rdy;
    beat_t b;
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(model_occ));
    model_grant(g, gv);
    load = !model_occ || out_ready;
    exp_rdy = (gv && load) ? N'(1 << g) : '0;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (gv && load) begin
      b.d = chan_data[g];
      b.c = SELW'(g);
      sb_q.push_back(b);
      model_occ = 1'b1;
      if (mode) model_rr = (g + 1) % int'(N);
    end else if (out_ready) begin
      model_occ = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_data();
    for (int i = 0; i < int'(N); i++) chan_data[i] = W'($urandom_range(255, 0));
  endtask

  // Monitor: any presented beat must match the oldest predicted one; it retires when accepted.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL beat_unexpected: got data=0x%0h chan=%0d expected no beat", out_data, out_chan);
      end else begin
        if ({out_data, out_chan} !== sb_q[0]) begin
          bad++;
          $display("FAIL beat: got data=0x%0h chan=%0d expected data=0x%0h chan=%0d",
                   out_data, out_chan, sb_q[0].d, sb_q[0].c);
        end
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    model_occ = 1'b0;
    model_rr = 0;
    rst_n = 1'b0;
    for (int i = 0; i < int'(N); i++) chan_data[i] = W'(8'h10 + i);
    drive(4'b1111, 1'b1, 2'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    check("rst_out_chan", 32'(out_chan), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'b0000);
    rst_n = 1'b1;
    drive(4'b0000, 1'b0, 2'd0, 1'b1);
    cycle();

    // Explicit select, then an idle selected channel.
    chan_data[2] = 8'hA5;
    drive(4'b0100, 1'b0, 2'd2, 1'b1);
    #1 check("sel2_in_ready", 32'(in_ready), 32'b0100);
    cycle();
    drive(4'b1011, 1'b0, 2'd2, 1'b1);
    #1 check("sel2_idle_in_ready", 32'(in_ready), 32'b0000);
    check("sel2_out_data", 32'(out_data), 32'hA5);
    cycle();
    cycle();

    // Round-robin with every channel valid.
    for (int i = 0; i < int'(N); i++) chan_data[i] = W'(8'h10 + i);
    drive(4'b1111, 1'b1, 2'd0, 1'b1);
    repeat (6) cycle();

    // Skip and wrap: grant ch2 leaves rr_ptr=3.
    drive(4'b0100, 1'b1, 2'd0, 1'b1);
    cycle();
    drive(4'b0010, 1'b1, 2'd0, 1'b1);
    #1 check("rr_skip_in_ready", 32'(in_ready), 32'b0010);
    cycle();
    drive(4'b0101, 1'b1, 2'd0, 1'b1);
    repeat (2) cycle();

    // Backpressure: hold 0x3C while ch1 waits with 0x77.
    chan_data[0] = 8'h3C;
    chan_data[1] = 8'h77;
    drive(4'b0001, 1'b0, 2'd0, 1'b1);
    cycle();
    drive(4'b0010, 1'b1, 2'd1, 1'b0);
    repeat (3) begin
      cycle();
      check("bp_hold_data", 32'(out_data), 32'h3C);
    end
    out_ready = 1'b1;
    cycle();
    check("bp_load_data", 32'(out_data), 32'h77);
    check("bp_load_valid", 32'(out_valid), 32'd1);

    // Async reset while stalled.
    drive(4'b1111, 1'b1, 2'd0, 1'b0);
    cycle();
    cycle();
    #2 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'b0000);
    sb_q.delete();
    model_occ = 1'b0;
    model_rr = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    #1 check("arst_restart_ch0", 32'(in_ready), 32'b0001);
    repeat (4) cycle();

    // Randomized traffic with mixed modes and backpressure.
    for (int n = 0; n < 3000; n++) begin
      rand_data();
      drive(N'($urandom_range(15, 0)), 1'($urandom_range(1, 0)),
            SELW'($urandom_range(3, 0)), ($urandom_range(3, 0) != 0));
      cycle();
    end

    drive(4'b0000, 1'b0, 2'd0, 1'b1);
    repeat (3) cycle();
    check("drain_empty", 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
